serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial N-bit adder built around the existing one-bit full_adder cell. It captures two operands and a carry-in on a start pulse, then adds one bit per clock, LSB first, feeding the cell's carry-out back through a register. It reports sum, carry-out and signed overflow with a single-cycle done pulse. It is the sequential consumer of the full_adder stage and trades area for WIDTH cycles of latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
clk      input   1      rising-edge clock
rst_n    input   1      asynchronous, active-low reset
start    input   1      request; sampled only in IDLE
a_in     input   WIDTH  operand A, captured on accepted start
b_in     input   WIDTH  operand B, captured on accepted start
cin      input   1      carry-in, captured on accepted start
busy     output  1      high in BUSY and DONE states
done     output  1      one-cycle completion pulse
sum_out  output  WIDTH  registered sum, holds until the next completion
cout     output  1      registered carry-out of the MSB
ovf      output  1      registered signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, sum_out=0, cout=0, ovf=0.
  - Internal shift registers, carry register and bit counter are cleared.
  - Reset takes effect immediately, including mid-operation. The in-flight operation is discarded and no done pulse is produced for it.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - start=1 at edge t loads A_sh<=a_in, B_sh<=b_in, c_reg<=cin, cnt<=0, and moves to BUSY.
  - start=0 keeps the block in IDLE.
- BUSY, each edge:
  - full_adder inputs are A_sh[0], B_sh[0], c_reg.
  - Its sum bit is shifted into the MSB of R_sh (right shift); A_sh and B_sh shift right.
  - c_reg<=fa_cout, cnt<=cnt+1.
  - Bit i is processed at edge t+1+i.
- Last bit (cnt==WIDTH-1), at edge t+WIDTH:
  - sum_out <= final R_sh value, including the incoming bit.
  - cout <= fa_cout.
  - ovf <= c_reg ^ fa_cout, where c_reg is the carry into the MSB.
  - State moves to DONE.
- DONE: done=1 for exactly the cycle between edges t+WIDTH and t+WIDTH+1, then unconditionally returns to IDLE.
- Latency: done is visible WIDTH cycles after the start edge. Minimum issue interval is WIDTH+2 cycles.
- start is ignored while busy=1. Captured operands are unaffected by a_in/b_in/cin changes after the accepted edge.
- start held high continuously: a new operation is accepted in every IDLE cycle.
- sum_out/cout/ovf change only at the completion edge or on reset, never during BUSY.
- WIDTH=1: single BUSY cycle; ovf = cin ^ cout.
- Counter width is clog2(WIDTH)+1 bits, so cnt never wraps.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'b00, BUSY=2'b01, DONE=2'b10; any other code recovers to IDLE.
  - counter-width function/constant.
- One sub-module: the existing full_adder, instantiated once, positional port order (a, b, cin, sum, cout).
- Datapath shift registers, FSM and output registers live in serial_adder.

Test Plan:
1. All with WIDTH=8. Reset: rst_n=0 at any time -> busy=0, done=0, sum_out=8'h00, cout=0, ovf=0 within the same cycle, without waiting for a clock edge.
2. a=8'h0F, b=8'h01, cin=0, start at edge t -> done=1 only after edge t+8; sum_out=8'h10, cout=0, ovf=0; busy high edges t..t+9.
3. Carry/overflow:
   - 8'hFF+8'h01, cin=0 -> sum 8'h00, cout=1, ovf=0.
   - 8'h7F+8'h01 -> sum 8'h80, cout=0, ovf=1.
   - 8'h80+8'h80 -> sum 8'h00, cout=1, ovf=1.
   - 8'hFF+8'hFF, cin=1 -> sum 8'hFF, cout=1, ovf=0.
4. Ignored start: start pulse with a=8'h55, b=8'hAA during BUSY of an op 8'h01+8'h02 -> result 8'h03. No second done; outputs stable until the next accepted start.
5. Reset mid-op: rst_n low at the fourth BUSY cycle of 8'h3C+8'h0F -> immediate clear, no done. After release, 8'h3C+8'h0F -> 8'h4B, cout=0, ovf=0.
6. Back-to-back: start held high with operand pairs (8'h01,8'h01), (8'hF0,8'h20) -> done pulses 10 cycles apart with sums 8'h02, then 8'h10 with cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes and counter sizing.
package serial_adder_pkg;

    // FSM state encoding; any other code recovers to IDLE.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Bit-counter width: one bit wider than needed so the counter never wraps.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell, the combinational stage reused by the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, one bit per clock,
// with registered sum/carry-out/signed-overflow and a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             ovf
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] r_next_s;

    full_adder u_fa (a_sh_q[0], b_sh_q[0], c_q, fa_sum_s, fa_cout_s);

    // Result shift register after this cycle's bit enters at the MSB (works for WIDTH=1 too).
    always_comb begin
        r_next_s            = r_sh_q >> 1;
        r_next_s[WIDTH-1]   = fa_sum_s;
    end

    // Next-state, datapath and output-register update logic.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = r_next_s;
                c_d    = fa_cout_s;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // c_q is the carry into the MSB here, fa_cout_s the carry out of it.
                    sum_d   = r_next_s;
                    cout_d  = fa_cout_s;
                    ovf_d   = c_q ^ fa_cout_s;
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == BUSY) || (state_d == DONE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with an expected-result queue.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             ovf;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse (accepted at the next posedge) and push the model's result.
    task automatic issue_op(input logic [7:0] a, input logic [7:0] b, input logic c);
        exp_t       e;
        logic [8:0] full;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; cin = c;
        full   = {1'b0, a} + {1'b0, b} + {8'b0, c};
        e.sum  = full[7:0];
        e.cout = full[8];
        e.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c;
    endtask

    // Sample on negedges until done; report latency, busy-high and output-hold status.
    task automatic wait_done(output bit found, output int lat, output bit busy_ok, output bit stable_ok);
        logic [7:0] hs;
        logic       hc;
        logic       ho;
        found = 1'b0; lat = -1; busy_ok = 1'b1; stable_ok = 1'b1;
        hs = sum_out; hc = cout; ho = ovf;
        for (int k = 0; k < 4 * WIDTH; k++) begin
            if (k > 0) @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                found = 1'b1;
                lat   = k;
                break;
            end
            if (sum_out !== hs || cout !== hc || ovf !== ho) stable_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a_in = 8'h00; b_in = 8'h00; cin = 1'b0;
        #2;
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (sum_out !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %h expected 00", sum_out); end
        n_cmp++; if (cout !== 1'b0)    begin n_err++; $display("FAIL reset_cout: got %b expected 0", cout); end
        n_cmp++; if (ovf !== 1'b0)     begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit   found, busy_ok, stable_ok;
        int   lat;
        exp_t e;
        issue_op(8'h0F, 8'h01, 1'b0);
        wait_done(found, lat, busy_ok, stable_ok);
        e = sb_q.pop_front();
        n_cmp++; if (!found)        begin n_err++; $display("FAIL basic_done_timeout: got no done expected done"); end
        n_cmp++; if (lat != WIDTH)  begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", lat, WIDTH); end
        n_cmp++; if (!busy_ok)      begin n_err++; $display("FAIL basic_busy: got low during op expected high"); end
        n_cmp++; if (!stable_ok)    begin n_err++; $display("FAIL basic_hold: got output change during BUSY expected hold"); end
        n_cmp++; if (sum_out !== e.sum) begin n_err++; $display("FAIL basic_sum: got %h expected %h", sum_out, e.sum); end
        n_cmp++; if (cout !== e.cout)   begin n_err++; $display("FAIL basic_cout: got %b expected %b", cout, e.cout); end
        n_cmp++; if (ovf !== e.ovf)     begin n_err++; $display("FAIL basic_ovf: got %b expected %b", ovf, e.ovf); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_drop: got %b expected 0", busy); end
    endtask

    task automatic test_carry_ovf();
        logic [16:0] vec [5];
        logic [16:0] v;
        bit          found, busy_ok, stable_ok;
        int          lat;
        exp_t        e;
        vec[0] = {8'hFF, 8'h01, 1'b0};
        vec[1] = {8'h7F, 8'h01, 1'b0};
        vec[2] = {8'h80, 8'h80, 1'b0};
        vec[3] = {8'hFF, 8'hFF, 1'b1};
        vec[4] = {8'h7F, 8'h00, 1'b1};
        for (int i = 0; i < 5; i++) begin
            v = vec[i];
            issue_op(v[16:9], v[8:1], v[0]);
            wait_done(found, lat, busy_ok, stable_ok);
            e = sb_q.pop_front();
            n_cmp++; if (!found || lat != WIDTH) begin n_err++; $display("FAIL carry_latency[%0d]: got %0d expected %0d", i, lat, WIDTH); end
            n_cmp++; if (sum_out !== e.sum) begin n_err++; $display("FAIL carry_sum[%0d]: got %h expected %h", i, sum_out, e.sum); end
            n_cmp++; if (cout !== e.cout)   begin n_err++; $display("FAIL carry_cout[%0d]: got %b expected %b", i, cout, e.cout); end
            n_cmp++; if (ovf !== e.ovf)     begin n_err++; $display("FAIL carry_ovf[%0d]: got %b expected %b", i, ovf, e.ovf); end
            n_cmp++; if (!stable_ok)        begin n_err++; $display("FAIL carry_hold[%0d]: got change during BUSY expected hold", i); end
        end
    endtask

    task automatic test_ignored_start();
        bit   found, busy_ok, stable_ok, ghost;
        int   lat;
        exp_t e;
        issue_op(8'h01, 8'h02, 1'b0);
        @(negedge clk);
        start = 1'b1; a_in = 8'h55; b_in = 8'hAA; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(found, lat, busy_ok, stable_ok);
        e = sb_q.pop_front();
        n_cmp++; if (!found || lat != WIDTH - 2) begin n_err++; $display("FAIL ign_latency: got %0d expected %0d", lat, WIDTH - 2); end
        n_cmp++; if (sum_out !== e.sum) begin n_err++; $display("FAIL ign_sum: got %h expected %h", sum_out, e.sum); end
        ghost = 1'b0;
        for (int k = 0; k < 3 * WIDTH; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || sum_out !== e.sum) ghost = 1'b1;
        end
        n_cmp++; if (ghost) begin n_err++; $display("FAIL ign_second_done: got extra done or output change expected none"); end
    endtask

    task automatic test_reset_mid_op();
        bit   found, busy_ok, stable_ok, ghost;
        int   lat;
        exp_t e;
        issue_op(8'h3C, 8'h0F, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
        n_cmp++; if (sum_out !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_err++; $display("FAIL midrst_out: got %h/%b/%b expected 00/0/0", sum_out, cout, ovf);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ghost = 1'b0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) ghost = 1'b1;
        end
        n_cmp++; if (ghost) begin n_err++; $display("FAIL midrst_no_done: got activity after reset expected idle"); end
        issue_op(8'h3C, 8'h0F, 1'b0);
        wait_done(found, lat, busy_ok, stable_ok);
        e = sb_q.pop_front();
        n_cmp++; if (!found || lat != WIDTH) begin n_err++; $display("FAIL midrst_latency: got %0d expected %0d", lat, WIDTH); end
        n_cmp++; if (sum_out !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            n_err++; $display("FAIL midrst_result: got %h/%b/%b expected %h/%b/%b", sum_out, cout, ovf, e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic test_back_to_back();
        int         done_k [2];
        int         n_done;
        logic [8:0] full;
        exp_t       e;
        @(negedge clk);
        start = 1'b1; a_in = 8'h01; b_in = 8'h01; cin = 1'b0;
        full = 9'h002; e.sum = full[7:0]; e.cout = full[8]; e.ovf = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        a_in = 8'hF0; b_in = 8'h20;
        full = {1'b0, 8'hF0} + {1'b0, 8'h20};
        e.sum = full[7:0]; e.cout = full[8]; e.ovf = 1'b0;
        sb_q.push_back(e);
        n_done = 0;
        for (int k = 0; k < 6 * WIDTH && n_done < 2; k++) begin
            if (k > 0) @(negedge clk);
            if (done === 1'b1) begin
                done_k[n_done] = k;
                n_done++;
                if (n_done == 2) start = 1'b0;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    n_cmp++; if (sum_out !== e.sum || cout !== e.cout) begin
                        n_err++; $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b", n_done - 1, sum_out, cout, e.sum, e.cout);
                    end
                end
            end
        end
        start = 1'b0;
        n_cmp++; if (n_done != 2) begin n_err++; $display("FAIL b2b_count: got %0d expected 2", n_done); end
        if (n_done == 2) begin
            n_cmp++; if (done_k[1] - done_k[0] != WIDTH + 2) begin
                n_err++; $display("FAIL b2b_gap: got %0d expected %0d", done_k[1] - done_k[0], WIDTH + 2);
            end
        end
        @(negedge clk); @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ovf();
        test_ignored_start();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
